// File: rtl/ooo_pkg.sv
// Shared out-of-order front-end types: decoded instruction payload and fetch width.
package ooo_pkg;

    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned REG_W     = 4;
    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned MAX_FETCH = 4;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [REG_W-1:0]     rt;
        logic [REG_W-1:0]     ra;
        logic [REG_W-1:0]     rb;
        logic                 a_dep;
        logic [ROB_TAG_W-1:0] a_owner;
        logic                 b_dep;
        logic [ROB_TAG_W-1:0] b_owner;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuf_ram.sv
// Entry storage for instr_buffer: lane-masked write ports, combinational read ports.
module ibuf_ram
    import ooo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DEQ_W = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAX_FETCH-1:0] wr_en,
    input  logic [PTR_W-1:0]     wr_addr [MAX_FETCH],
    input  ibuf_entry_t          wr_data [MAX_FETCH],
    input  logic [PTR_W-1:0]     rd_addr [DEQ_W],
    output ibuf_entry_t          rd_data [DEQ_W]
);

    ibuf_entry_t mem_q [DEPTH];

    // Cleared on reset so the deq lanes read zero before anything is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned l = 0; l < MAX_FETCH; l++) begin
                if (wr_en[l]) begin
                    mem_q[wr_addr[l]] <= wr_data[l];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < DEQ_W; r++) begin
            rd_data[r] = mem_q[rd_addr[r]];
        end
    end

endmodule

// File: rtl/instr_buffer.sv
// Decoded-instruction FIFO between decode and dispatch with fetch-width feedback.
// IBUF_BYPASS_EN: when empty, deq lanes mirror the incoming enq lanes in the same cycle.
module instr_buffer
    import ooo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DEQ_W = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1,
    localparam int unsigned DVC_W = $clog2(DEQ_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [2:0]       enq_count,
    input  ibuf_entry_t      enq_entry [MAX_FETCH],
    output logic [2:0]       fetch_slots,
    output ibuf_entry_t      deq_entry [DEQ_W],
    output logic [DVC_W-1:0] deq_valid_count,
    input  logic [DVC_W-1:0] deq_take,
    output logic [CNT_W-1:0] occupancy,
    output logic             overflow
);

    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;
    logic                 overflow_q;

    logic [CNT_W-1:0]     free_c;
    logic                 enq_fits_c;
    logic                 bypass_c;
    logic [2:0]           enq_acc_c;
    logic [2:0]           skip_c;
    logic [DVC_W-1:0]     ram_valid_c;
    logic [DVC_W-1:0]     deq_vis_c;
    logic [DVC_W-1:0]     take_c;
    logic [DVC_W-1:0]     head_adv_c;
    logic [MAX_FETCH-1:0] wr_en_c;
    logic [PTR_W-1:0]     wr_addr_c [MAX_FETCH];
    logic [PTR_W-1:0]     rd_addr_c [DEQ_W];
    ibuf_entry_t          rd_data_c [DEQ_W];

    // Capacity and visible-entry counts depend on the count register only
    always_comb begin
        free_c      = CNT_W'(DEPTH) - count_q;
        fetch_slots = (free_c >= CNT_W'(MAX_FETCH)) ? 3'(MAX_FETCH) : 3'(free_c);
        ram_valid_c = (count_q >= CNT_W'(DEQ_W)) ? DVC_W'(DEQ_W) : DVC_W'(count_q);
    end

`ifdef IBUF_BYPASS_EN
    assign bypass_c = (count_q == '0) && !flush;
`else
    assign bypass_c = 1'b0;
`endif

    // Group accept, dequeue clamp and per-lane write addresses; bypassed lanes are never written
    always_comb begin
        enq_fits_c = (enq_count <= fetch_slots);
        enq_acc_c  = (!flush && enq_fits_c) ? enq_count : 3'd0;
        if (bypass_c) begin
            deq_vis_c = !enq_fits_c ? '0 :
                        (enq_count >= 3'(DEQ_W)) ? DVC_W'(DEQ_W) : DVC_W'(enq_count);
        end else begin
            deq_vis_c = ram_valid_c;
        end
        take_c     = (deq_take > deq_vis_c) ? deq_vis_c : deq_take;
        skip_c     = bypass_c ? 3'(take_c) : 3'd0;
        head_adv_c = bypass_c ? '0 : take_c;
        for (int unsigned i = 0; i < MAX_FETCH; i++) begin
            wr_en_c[i]   = (3'(i) < enq_acc_c) && (3'(i) >= skip_c);
            wr_addr_c[i] = tail_q + PTR_W'(3'(i) - skip_c);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            rd_addr_c[i] = head_q + PTR_W'(i);
            deq_entry[i] = bypass_c ? enq_entry[i] : rd_data_c[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(head_adv_c);
            tail_q  <= tail_q + PTR_W'(enq_acc_c - skip_c);
            count_q <= count_q + CNT_W'(enq_acc_c) - CNT_W'(take_c);
        end
    end

    // Sticky: a dropped group is a fetch-side protocol error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (!flush && !enq_fits_c) begin
            overflow_q <= 1'b1;
        end
    end

    assign deq_valid_count = deq_vis_c;
    assign occupancy       = count_q;
    assign overflow        = overflow_q;

    ibuf_ram #(
        .DEPTH (DEPTH),
        .DEQ_W (DEQ_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_addr (wr_addr_c),
        .wr_data (enq_entry),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data_c)
    );

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_buffer;
    import ooo_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DEQ_W = 2;
    localparam int unsigned DVC_W = $clog2(DEQ_W + 1);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [2:0]       enq_count;
    ibuf_entry_t      enq_entry [MAX_FETCH];
    logic [2:0]       fetch_slots;
    ibuf_entry_t      deq_entry [DEQ_W];
    logic [DVC_W-1:0] deq_valid_count;
    logic [DVC_W-1:0] deq_take;
    logic [OCC_W-1:0] occupancy;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    ibuf_entry_t mq [$];
    bit          m_ovf;
    ibuf_entry_t lane_data [MAX_FETCH];

    always #5 clk = ~clk;

    instr_buffer #(.DEPTH(DEPTH), .DEQ_W(DEQ_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .enq_count       (enq_count),
        .enq_entry       (enq_entry),
        .fetch_slots     (fetch_slots),
        .deq_entry       (deq_entry),
        .deq_valid_count (deq_valid_count),
        .deq_take        (deq_take),
        .occupancy       (occupancy),
        .overflow        (overflow)
    );

    function automatic int exp_slots();
        int f = DEPTH - mq.size();
        return (f < 4) ? f : 4;
    endfunction

    function automatic int exp_vis();
        return (mq.size() < DEQ_W) ? mq.size() : DEQ_W;
    endfunction

    task automatic rand_lanes();
        for (int i = 0; i < MAX_FETCH; i++) lane_data[i] = 26'($urandom);
    endtask

    task automatic set_opcodes(input int base);
        rand_lanes();
        for (int i = 0; i < MAX_FETCH; i++) lane_data[i].opcode = 4'(base + i);
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge
    task automatic cycle(input int n, input int tk, input bit fl);
        int vis;
        int t;
        ibuf_entry_t e;
        enq_count = 3'(n);
        deq_take  = DVC_W'(tk);
        flush     = fl;
        for (int i = 0; i < MAX_FETCH; i++) enq_entry[i] = lane_data[i];
        vis = exp_vis();
`ifdef IBUF_BYPASS_EN
        if (mq.size() == 0 && !fl) vis = (n > 4) ? 0 : ((n < DEQ_W) ? n : DEQ_W);
`endif
        t = (tk < vis) ? tk : vis;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (n > exp_slots()) m_ovf = 1'b1;
            else for (int i = 0; i < n; i++) mq.push_back(lane_data[i]);
            repeat (t) e = mq.pop_front();
        end
        #1;
        enq_count = '0;
        deq_take  = '0;
        flush     = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        enq_count = '0;
        deq_take  = '0;
        for (int i = 0; i < MAX_FETCH; i++) enq_entry[i] = '0;
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0; enq_count = '0; deq_take = '0;
        for (int i = 0; i < MAX_FETCH; i++) enq_entry[i] = '0;
        #2;
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (fetch_slots !== 3'd4) begin failures++; $display("FAIL reset_slots got=%0d exp=4", fetch_slots); end
        checks++; if (deq_valid_count !== '0) begin failures++; $display("FAIL reset_dvc got=%0d exp=0", deq_valid_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", overflow); end
        checks++; if (deq_entry[0] !== '0) begin failures++; $display("FAIL reset_entry got=%h exp=0", deq_entry[0]); end
        do_reset();
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int c = 0; c < 4; c++) begin rand_lanes(); cycle(4, 0, 0); end
        checks++; if (occupancy !== OCC_W'(16)) begin failures++; $display("FAIL full_occ got=%0d exp=16", occupancy); end
        checks++; if (fetch_slots !== 3'd0) begin failures++; $display("FAIL full_slots got=%0d exp=0", fetch_slots); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_ovf got=%0d exp=0", overflow); end
        rand_lanes();
        cycle(1, 0, 0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0d exp=1", overflow); end
        checks++; if (occupancy !== OCC_W'(16)) begin failures++; $display("FAIL ovf_occ got=%0d exp=16", occupancy); end
        checks++; if (deq_entry[0] !== mq[0]) begin failures++; $display("FAIL ovf_head got=%h exp=%h", deq_entry[0], mq[0]); end
        cycle(0, 0, 1);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0d exp=1", overflow); end
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL ovf_flush_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_order();
        do_reset();
        set_opcodes(1);
        cycle(3, 2, 0);
`ifndef IBUF_BYPASS_EN
        checks++; if (deq_valid_count !== DVC_W'(2)) begin failures++; $display("FAIL order_dvc0 got=%0d exp=2", deq_valid_count); end
        checks++; if (deq_entry[0].opcode !== 4'd1) begin failures++; $display("FAIL order_l0 got=%0d exp=1", deq_entry[0].opcode); end
        checks++; if (deq_entry[1].opcode !== 4'd2) begin failures++; $display("FAIL order_l1 got=%0d exp=2", deq_entry[1].opcode); end
        cycle(0, 2, 0);
        checks++; if (deq_valid_count !== DVC_W'(1)) begin failures++; $display("FAIL order_dvc1 got=%0d exp=1", deq_valid_count); end
        checks++; if (deq_entry[0].opcode !== 4'd3) begin failures++; $display("FAIL order_l0b got=%0d exp=3", deq_entry[0].opcode); end
`endif
        cycle(0, 2, 0);
        checks++; if (occupancy !== OCC_W'(mq.size())) begin failures++; $display("FAIL order_occ got=%0d exp=%0d", occupancy, mq.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 3; c++) begin rand_lanes(); cycle(4, 0, 0); end
        rand_lanes();
        cycle(2, 0, 0);
        checks++; if (occupancy !== OCC_W'(14)) begin failures++; $display("FAIL wrap_fill got=%0d exp=14", occupancy); end
        for (int c = 0; c < 7; c++) begin
            checks++; if (deq_entry[0] !== mq[0] || deq_entry[1] !== mq[1]) begin
                failures++; $display("FAIL wrap_drain_data got=%h/%h exp=%h/%h", deq_entry[0], deq_entry[1], mq[0], mq[1]);
            end
            cycle(0, 2, 0);
            checks++; if (occupancy !== OCC_W'(12 - 2 * c)) begin failures++; $display("FAIL wrap_drain_occ got=%0d exp=%0d", occupancy, 12 - 2 * c); end
        end
        set_opcodes(10);
        cycle(4, 0, 0);
        checks++; if (occupancy !== OCC_W'(4)) begin failures++; $display("FAIL wrap_occ got=%0d exp=4", occupancy); end
        checks++; if (deq_entry[0].opcode !== 4'd10 || deq_entry[1].opcode !== 4'd11) begin
            failures++; $display("FAIL wrap_first got=%0d,%0d exp=10,11", deq_entry[0].opcode, deq_entry[1].opcode);
        end
        cycle(0, 2, 0);
        checks++; if (deq_entry[0].opcode !== 4'd12 || deq_entry[1].opcode !== 4'd13) begin
            failures++; $display("FAIL wrap_second got=%0d,%0d exp=12,13", deq_entry[0].opcode, deq_entry[1].opcode);
        end
        cycle(0, 2, 0);
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL wrap_empty got=%0d exp=0", occupancy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        rand_lanes(); cycle(4, 0, 0);
        rand_lanes(); cycle(4, 0, 0);
        rand_lanes(); cycle(2, 0, 0);
        checks++; if (occupancy !== OCC_W'(10)) begin failures++; $display("FAIL sim_pre got=%0d exp=10", occupancy); end
        rand_lanes();
        cycle(3, 2, 0);
        checks++; if (occupancy !== OCC_W'(11)) begin failures++; $display("FAIL sim_occ got=%0d exp=11", occupancy); end
        checks++; if (fetch_slots !== 3'd4) begin failures++; $display("FAIL sim_slots got=%0d exp=4", fetch_slots); end
        checks++; if (deq_entry[0] !== mq[0]) begin failures++; $display("FAIL sim_head got=%h exp=%h", deq_entry[0], mq[0]); end
    endtask

    task automatic test_flush();
        do_reset();
        rand_lanes(); cycle(4, 0, 0);
        rand_lanes(); cycle(3, 0, 0);
        checks++; if (occupancy !== OCC_W'(7)) begin failures++; $display("FAIL flush_pre got=%0d exp=7", occupancy); end
        rand_lanes();
        cycle(4, 1, 1);
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        checks++; if (deq_valid_count !== '0) begin failures++; $display("FAIL flush_dvc got=%0d exp=0", deq_valid_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf got=%0d exp=0", overflow); end
        set_opcodes(9);
        cycle(1, 0, 0);
        checks++; if (deq_valid_count !== DVC_W'(1) || deq_entry[0].opcode !== 4'd9) begin
            failures++; $display("FAIL flush_after got=%0d/%0d exp=1/9", deq_valid_count, deq_entry[0].opcode);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rand_lanes(); cycle(4, 0, 0);
        rand_lanes(); cycle(7, 0, 0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < MAX_FETCH; i++) enq_entry[i] = '0;
        #1;
        checks++; if (occupancy !== '0) begin failures++; $display("FAIL arst_occ got=%0d exp=0", occupancy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL arst_ovf got=%0d exp=0", overflow); end
        checks++; if (fetch_slots !== 3'd4 || deq_valid_count !== '0) begin
            failures++; $display("FAIL arst_flags got=%0d/%0d exp=4/0", fetch_slots, deq_valid_count);
        end
        checks++; if (deq_entry[0] !== '0) begin failures++; $display("FAIL arst_entry got=%h exp=0", deq_entry[0]); end
        do_reset();
    endtask

    task automatic test_bypass();
`ifdef IBUF_BYPASS_EN
        do_reset();
        set_opcodes(1);
        enq_count = 3'd3;
        deq_take  = DVC_W'(2);
        for (int i = 0; i < MAX_FETCH; i++) enq_entry[i] = lane_data[i];
        #1;
        checks++; if (deq_valid_count !== DVC_W'(2)) begin failures++; $display("FAIL byp_dvc got=%0d exp=2", deq_valid_count); end
        checks++; if (deq_entry[0] !== lane_data[0] || deq_entry[1] !== lane_data[1]) begin
            failures++; $display("FAIL byp_lanes got=%h/%h exp=%h/%h", deq_entry[0], deq_entry[1], lane_data[0], lane_data[1]);
        end
        cycle(3, 2, 0);
        checks++; if (occupancy !== OCC_W'(1)) begin failures++; $display("FAIL byp_occ got=%0d exp=1", occupancy); end
        checks++; if (deq_entry[0] !== lane_data[2]) begin failures++; $display("FAIL byp_l2 got=%h exp=%h", deq_entry[0], lane_data[2]); end
`endif
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rand_lanes();
            n = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, exp_slots()));
            cycle(n, int'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
            checks++; if (occupancy !== OCC_W'(mq.size())) begin failures++; $display("FAIL rnd_occ k=%0d got=%0d exp=%0d", k, occupancy, mq.size()); end
            checks++; if (fetch_slots !== 3'(exp_slots())) begin failures++; $display("FAIL rnd_slots k=%0d got=%0d exp=%0d", k, fetch_slots, exp_slots()); end
            checks++; if (deq_valid_count !== DVC_W'(exp_vis())) begin failures++; $display("FAIL rnd_dvc k=%0d got=%0d exp=%0d", k, deq_valid_count, exp_vis()); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf k=%0d got=%0d exp=%0d", k, overflow, m_ovf); end
            for (int i = 0; i < exp_vis(); i++) begin
                checks++; if (deq_entry[i] !== mq[i]) begin failures++; $display("FAIL rnd_entry k=%0d lane=%0d got=%h exp=%h", k, i, deq_entry[i], mq[i]); end
            end
            if (k == 200) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_order();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
